// File: rtl/moxie_ifetch_wb.sv
// Wishbone instruction-fetch master for the Moxie core: sequential word reads
// into a DEPTH-entry prefetch queue, with branch redirect/flush and halt on bus error.
module moxie_ifetch_wb #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           DEPTH        = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h00001000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic [ADDR_WIDTH-1:0]   target_i,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_we_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  output logic                    valid_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic                    err_o,
  input  logic                    ready_i,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int unsigned           BYTES      = DATA_WIDTH / 8;
  localparam int unsigned           PW         = $clog2(DEPTH);
  localparam int unsigned           CW         = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADR_STEP   = ADDR_WIDTH'(BYTES);
  localparam logic [CW-1:0]         DEPTH_C    = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUS, HALT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic                  cyc_q;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic                  pop, push, push_err;
  logic                  room, room_after_push;

  logic [DATA_WIDTH-1:0] ent_data [DEPTH];
  logic [ADDR_WIDTH-1:0] ent_addr [DEPTH];
  logic                  ent_err  [DEPTH];

  assign pop             = (count_q != '0) && ready_i && !flush_i;
  assign room            = (count_q - CW'(pop)) < DEPTH_C;
  // A request is only kept on the bus when its termination is sure to find a free slot.
  assign room_after_push = (count_q + CW'(1) - CW'(pop)) < DEPTH_C;

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    push     = 1'b0;
    push_err = 1'b0;
    case (state_q)
      IDLE: if (room) state_d = BUS;
      BUS: begin
        if (wb_err_i) begin
          push     = 1'b1;
          push_err = 1'b1;
          state_d  = HALT;
        end else if (wb_ack_i) begin
          push    = 1'b1;
          adr_d   = adr_q + ADR_STEP;
          state_d = room_after_push ? BUS : IDLE;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    // A pending request without termination must be dropped for one cycle before redirecting.
    if (flush_i) begin
      push     = 1'b0;
      push_err = 1'b0;
      adr_d    = target_i & ALIGN_MASK;
      state_d  = (state_q == BUS && !wb_ack_i && !wb_err_i) ? IDLE : BUS;
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      adr_q    <= RESET_VECTOR;
      cyc_q    <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      cyc_q    <= (state_d == BUS);
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        data_q <= '0;
        addr_q <= '0;
        err_q  <= 1'b0;
      end else if (push && (wr_ptr_q == PW'(gi))) begin
        data_q <= wb_dat_i;
        addr_q <= adr_q;
        err_q  <= push_err;
      end
    end

    assign ent_data[gi] = data_q;
    assign ent_addr[gi] = addr_q;
    assign ent_err[gi]  = err_q;
  end

  assign wb_adr_o = adr_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = '1;
  assign valid_o  = (count_q != '0);
  assign data_o   = ent_data[rd_ptr_q];
  assign addr_o   = ent_addr[rd_ptr_q];
  assign err_o    = ent_err[rd_ptr_q];
  assign count_o  = count_q;

endmodule

// File: tb/tb_moxie_ifetch_wb.sv
// Randomised and directed bench for moxie_ifetch_wb against a queue-based
// model of the prefetch buffer and the sequential fetch address.
module tb_moxie_ifetch_wb;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_1000;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, ready = 1'b0;
  logic        ack = 1'b0, berr = 1'b0;
  logic [31:0] target = '0, dat = '0;
  logic [31:0] wb_adr_o, data_o, addr_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, valid_o, err_o;
  logic [2:0]  count_o;

  int checks = 0, errors = 0;
  int wait_n = 0, wcnt = 0;
  bit err_en = 1'b0;
  logic [31:0] err_addr = '0;
  logic [31:0] m_addr[$];
  bit          m_err[$];
  logic [31:0] next_fetch = RV;
  int acks = 0, pops = 0, cyc_highs = 0;

  moxie_ifetch_wb #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .RESET_VECTOR(RV)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .target_i(target),
    .wb_adr_o(wb_adr_o), .wb_dat_i(dat), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(ack), .wb_err_i(berr),
    .valid_o(valid_o), .data_o(data_o), .addr_o(addr_o), .err_o(err_o),
    .ready_i(ready), .count_o(count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] wdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic model_reset();
    m_addr.delete();
    m_err.delete();
    next_fetch = RV;
    wcnt = 0;
  endtask

  // One clock cycle: slave answers, outputs are compared to the model, model advances.
  // Entered and left at a falling edge.
  task automatic step();
    bit do_pop, do_push;
    ack = 1'b0;
    berr = 1'b0;
    if (wb_cyc_o !== 1'b1) wcnt = 0;
    else if (wcnt >= wait_n) begin
      wcnt = 0;
      dat = wdata(wb_adr_o);
      if (err_en && wb_adr_o == err_addr) berr = 1'b1;
      else ack = 1'b1;
    end else wcnt++;

    checks++;
    if ({29'd0, count_o} !== 32'(m_addr.size())) begin
      errors++;
      $display("FAIL count: got %0d expected %0d", count_o, m_addr.size());
    end
    checks++;
    if (valid_o !== (m_addr.size() != 0)) begin
      errors++;
      $display("FAIL valid: got %0b expected %0b", valid_o, m_addr.size() != 0);
    end
    if (m_addr.size() != 0) begin
      checks++;
      if (addr_o !== m_addr[0] || data_o !== wdata(m_addr[0]) || err_o !== m_err[0]) begin
        errors++;
        $display("FAIL head: got addr %h data %h err %0b expected addr %h data %h err %0b",
                 addr_o, data_o, err_o, m_addr[0], wdata(m_addr[0]), m_err[0]);
      end
    end
    if (wb_cyc_o === 1'b1) begin
      checks++;
      if (wb_adr_o !== next_fetch) begin
        errors++;
        $display("FAIL fetch_addr: got %h expected %h", wb_adr_o, next_fetch);
      end
    end
    checks++;
    if (wb_stb_o !== wb_cyc_o || count_o > 3'(DEPTH)) begin
      errors++;
      $display("FAIL stb_or_bound: got stb %0b cyc %0b count %0d expected stb=cyc count<=%0d",
               wb_stb_o, wb_cyc_o, count_o, DEPTH);
    end

    do_pop  = (m_addr.size() != 0) && ready && !flush;
    do_push = (wb_cyc_o === 1'b1) && (ack || berr) && !flush;
    if (wb_cyc_o === 1'b1) cyc_highs++;
    if (flush) begin
      m_addr.delete();
      m_err.delete();
      next_fetch = target & ~32'h3;
    end else begin
      if (do_pop) begin
        void'(m_addr.pop_front());
        void'(m_err.pop_front());
        pops++;
      end
      if (do_push) begin
        m_addr.push_back(next_fetch);
        m_err.push_back(berr);
        acks++;
        if (!berr) next_fetch = next_fetch + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ack = 1'b0;
    berr = 1'b0;
    flush = 1'b0;
    err_en = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    pops = 0;
    cyc_highs = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0 || wb_sel_o !== 4'hF) begin
      errors++;
      $display("FAIL reset_bus: got cyc %0b stb %0b we %0b sel %h expected 0 0 0 f",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o);
    end
    checks++;
    if (wb_adr_o !== RV || valid_o !== 1'b0 || count_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got adr %h valid %0b count %0d expected %h 0 0",
               wb_adr_o, valid_o, count_o, RV);
    end
    checks++;
    if (data_o !== 32'd0 || addr_o !== 32'd0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_head: got data %h addr %h err %0b expected zeros", data_o, addr_o, err_o);
    end
    model_reset();
    rst = 1'b0;
    step();
    checks++;
    if (wb_cyc_o !== 1'b1 || wb_adr_o !== RV) begin
      errors++;
      $display("FAIL first_request: got cyc %0b adr %h expected 1 %h", wb_cyc_o, wb_adr_o, RV);
    end
  endtask

  task automatic test_stream();
    ready = 1'b1;
    wait_n = 0;
    acks = 0;
    pops = 0;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (acks != 12 || pops != 11) begin
      errors++;
      $display("FAIL stream_rate: got acks %0d pops %0d expected 12 11", acks, pops);
    end
  endtask

  task automatic test_full();
    do_reset();
    ready = 1'b0;
    wait_n = 0;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (acks != DEPTH || wb_cyc_o !== 1'b0 || count_o !== 3'(DEPTH)) begin
      errors++;
      $display("FAIL full_stop: got acks %0d cyc %0b count %0d expected %0d 0 %0d",
               acks, wb_cyc_o, count_o, DEPTH, DEPTH);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++;
    if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h1010) begin
      errors++;
      $display("FAIL refill_req: got cyc %0b adr %h expected 1 00001010", wb_cyc_o, wb_adr_o);
    end
    acks = 0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (acks != 1 || count_o !== 3'(DEPTH)) begin
      errors++;
      $display("FAIL refill_once: got acks %0d count %0d expected 1 %0d", acks, count_o, DEPTH);
    end
  endtask

  task automatic test_flush_abort();
    bit found = 1'b0;
    do_reset();
    ready = 1'b0;
    wait_n = 3;
    for (int i = 0; i < 40 && !found; i++) begin
      if (count_o >= 3'd1 && wb_cyc_o === 1'b1 && wcnt < wait_n) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_setup: got no pending request expected one within 40 cycles");
    end
    flush = 1'b1;
    target = 32'h2002;
    step();
    flush = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || count_o !== 3'd0 || wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_cycle: got valid %0b count %0d cyc %0b expected 0 0 0",
               valid_o, count_o, wb_cyc_o);
    end
    step();
    checks++;
    if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h2000) begin
      errors++;
      $display("FAIL abort_restart: got cyc %0b adr %h expected 1 00002000", wb_cyc_o, wb_adr_o);
    end
    for (int i = 0; i < 10 && valid_o !== 1'b1; i++) step();
    checks++;
    if (valid_o !== 1'b1 || addr_o !== 32'h2000) begin
      errors++;
      $display("FAIL abort_first_word: got valid %0b addr %h expected 1 00002000", valid_o, addr_o);
    end
    ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_flush_ack();
    do_reset();
    ready = 1'b1;
    wait_n = 0;
    for (int i = 0; i < 4; i++) step();
    flush = 1'b1;
    target = 32'h2400;
    step();
    flush = 1'b0;
    checks++;
    if (count_o !== 3'd0 || valid_o !== 1'b0 || wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h2400) begin
      errors++;
      $display("FAIL flush_ack: got count %0d valid %0b cyc %0b adr %h expected 0 0 1 00002400",
               count_o, valid_o, wb_cyc_o, wb_adr_o);
    end
    for (int i = 0; i < 5 && valid_o !== 1'b1; i++) step();
    checks++;
    if (addr_o !== 32'h2400) begin
      errors++;
      $display("FAIL flush_ack_first: got addr %h expected 00002400", addr_o);
    end
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_bus_error();
    do_reset();
    ready = 1'b0;
    wait_n = 1;
    err_en = 1'b1;
    err_addr = 32'h100C;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (acks != 4 || count_o !== 3'd4 || wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL err_halt: got terms %0d count %0d cyc %0b expected 4 4 0", acks, count_o, wb_cyc_o);
    end
    cyc_highs = 0;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (addr_o !== 32'h100C || err_o !== 1'b1 || count_o !== 3'd1) begin
      errors++;
      $display("FAIL err_entry: got addr %h err %0b count %0d expected 0000100c 1 1",
               addr_o, err_o, count_o);
    end
    step();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (cyc_highs != 0 || count_o !== 3'd0) begin
      errors++;
      $display("FAIL err_no_fetch: got cyc cycles %0d count %0d expected 0 0", cyc_highs, count_o);
    end
    err_en = 1'b0;
    flush = 1'b1;
    target = 32'h3000;
    step();
    flush = 1'b0;
    checks++;
    if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h3000) begin
      errors++;
      $display("FAIL err_resume: got cyc %0b adr %h expected 1 00003000", wb_cyc_o, wb_adr_o);
    end
    ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    do_reset();
    ready = 1'b0;
    wait_n = 3;
    for (int i = 0; i < 40 && !found; i++) begin
      if (count_o >= 3'd1 && wb_cyc_o === 1'b1) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL areset_setup: got no busy state expected one within 40 cycles");
    end
    rst = 1'b1;
    ack = 1'b1;
    dat = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_adr_o !== RV || valid_o !== 1'b0 ||
        count_o !== 3'd0 || data_o !== 32'd0 || addr_o !== 32'd0) begin
      errors++;
      $display("FAIL areset_immediate: got cyc %0b adr %h valid %0b count %0d data %h addr %h expected 0 %h 0 0 0 0",
               wb_cyc_o, wb_adr_o, valid_o, count_o, data_o, addr_o, RV);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (count_o !== 3'd0 || wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL areset_ack_ignored: got count %0d cyc %0b expected 0 0", count_o, wb_cyc_o);
    end
    ack = 1'b0;
    model_reset();
    rst = 1'b0;
    step();
    ready = 1'b1;
    wait_n = 0;
    pops = 0;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (pops != 5) begin
      errors++;
      $display("FAIL areset_recover: got pops %0d expected 5", pops);
    end
  endtask

  task automatic test_random();
    int goal = 3 * DEPTH + 1;
    do_reset();
    for (int i = 0; i < 400 && pops < goal; i++) begin
      ready = 1'($urandom_range(0, 1));
      wait_n = $urandom_range(0, 1);
      step();
    end
    checks++;
    if (pops < goal) begin
      errors++;
      $display("FAIL random_delivery: got %0d words expected at least %0d", pops, goal);
    end
    // Push and pop together while one slot short of full.
    do_reset();
    ready = 1'b0;
    wait_n = 0;
    for (int i = 0; i < 10 && count_o !== 3'(DEPTH - 1); i++) step();
    ready = 1'b1;
    step();
    checks++;
    if (count_o !== 3'(DEPTH - 1) || wb_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL push_pop_near_full: got count %0d cyc %0b expected %0d 1",
               count_o, wb_cyc_o, DEPTH - 1);
    end
    for (int i = 0; i < 2 * DEPTH; i++) begin
      ready = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_flush_abort();
    test_flush_ack();
    test_bus_error();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/moxie_ifetch_wb.md
# moxie_ifetch_wb

Parametrised Wishbone instruction-fetch master with a prefetch queue for the Moxie core. It sits between the core's instruction Wishbone port and the fetch stage, replacing the single free-running strobe register. It issues sequential word reads and buffers up to DEPTH words with their addresses. It also supports redirect/flush on branches and halts fetching on bus error.

## Interface
- ADDR_WIDTH, 32, Wishbone address width
- DATA_WIDTH, 32, instruction word width; multiple of 8
- DEPTH, 4, prefetch queue entries; power of two, >= 2
- RESET_VECTOR, 32'h00001000, first fetch address after reset; word aligned

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  redirect request (branch taken)
- target_i  in  ADDR_WIDTH  redirect address; low log2(DATA_WIDTH/8) bits ignored
- wb_adr_o  out  ADDR_WIDTH  Wishbone address, registered
- wb_dat_i  in  DATA_WIDTH  Wishbone read data
- wb_sel_o  out  DATA_WIDTH/8  byte selects, constant all ones
- wb_we_o  out  1  constant 0
- wb_cyc_o  out  1  bus cycle, registered
- wb_stb_o  out  1  strobe, registered, always equal to wb_cyc_o
- wb_ack_i  in  1  Wishbone acknowledge
- wb_err_i  in  1  Wishbone error termination
- valid_o  out  1  queue head valid (count_o != 0)
- data_o  out  DATA_WIDTH  head instruction word
- addr_o  out  ADDR_WIDTH  address the head word was fetched from
- err_o  out  1  head entry ended in bus error
- ready_i  in  1  consumer pops head when valid_o & ready_i
- count_o  out  log2(DEPTH)+1  queue occupancy

## Operation
- Classic Wishbone, one outstanding request max. Requests are sequential; the fetch address advances by DATA_WIDTH/8 per accepted word.
- States:
  - IDLE: cyc=stb=0.
  - BUS: cyc=stb=1; wb_adr_o holds the fetch address.
  - HALT: cyc=stb=0; entered after an error.
- pop = valid_o & ready_i & !flush_i. room = (count_o - pop) < DEPTH.
- IDLE -> BUS when room. Otherwise stay in IDLE.
- BUS with ack and no flush:
  - Push {wb_dat_i, wb_adr_o, err=0}; advance the fetch address.
  - Stay in BUS (back-to-back, new address next cycle) if (count_o + 1 - pop) < DEPTH; else go to IDLE.
- BUS with err and no flush: push {wb_dat_i, wb_adr_o, err=1}, then go to HALT. HALT exits only on flush.
- ack and err both high: treated as err.
- Flush, any state:
  - Queue cleared (count_o=0, pointers reset); the fetch address becomes target_i word-aligned. Flush has priority over pop and push.
  - Ack/err in the flush cycle is discarded.
  - If the flush cycle is BUS with no ack/err, the cycle is aborted: go to IDLE (cyc low for one cycle), then BUS.
  - Otherwise go directly to BUS with the target address.
- Queue: circular, read/write pointers wrap mod DEPTH. Head fields are combinational from storage at the read pointer. Simultaneous push and pop leaves the count unchanged.
- Occupancy never exceeds DEPTH; a request is issued only when a slot is guaranteed at termination.

## Timing
- Reset values: wb_cyc_o=wb_stb_o=0, wb_adr_o=RESET_VECTOR, wb_we_o=0, wb_sel_o=all ones, valid_o=0, count_o=0, data_o=0, addr_o=0, err_o=0 (storage reset to 0), state IDLE.
- First request: wb_cyc_o rises on the first edge after rst_i deasserts.
- Ack at edge N -> valid_o/data_o at N+1 (1-cycle latency minimum).
- With a zero-wait slave and ready_i=1: one word per cycle sustained.
- Flush at edge N -> valid_o=0 from N+1.
  - wb_stb_o with adr=target at N+1 if no abort is needed, else at N+2.
- Reset asserted mid-cycle: outputs return to reset values immediately (asynchronous); the in-flight ack is ignored.

## Test plan
- Reset, zero-wait slave returning data=address, ready_i=1 -> wb_adr_o 0x1000,0x1004,0x1008…; data_o/addr_o match in order, one per cycle after the first.
- ready_i=0, DEPTH=4 -> exactly four acks, then wb_cyc_o=0, count_o=4; one pop -> exactly one new request at 0x1010.
- Slave 3-wait-states; flush_i with target_i=0x2002 while stb pending -> cyc low one cycle, then adr=0x2000; the late slave response never enters the queue; valid_o=0 the cycle after the flush.
- Flush coincident with ack and ready_i=1 -> acked word neither delivered nor popped; next wb_adr_o=target; count_o=0.
- wb_err_i on 0x100C -> entries 0x1000-0x1008 with err_o=0, then 0x100C with err_o=1; no further cyc until flush; flush to 0x3000 resumes fetching.
- Random ready_i over 3*DEPTH+1 words, including push+pop at count_o=DEPTH-1 -> no loss, no duplication, order preserved across pointer wrap; count_o never >DEPTH.
